// File: rtl/bpsk_rx_ctrl.sv
// bpsk_rx_ctrl: BPSK receive bit-timing recovery, differential decode and 32-bit word packing into frame BRAM
module bpsk_rx_ctrl #(
  parameter int data_width = 32,
  parameter int frame_length = 38,
  parameter int addr_width = 32,
  parameter int ref_clk_freq = 128000000,
  parameter int baudrate = 9600
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_enable,
  input  logic                  phase_in,
  output logic                  ram_clk,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_wr_data,
  output logic                  ram_rst,
  output logic                  bit_tick,
  output logic                  bit_out,
  output logic                  frame_done,
  output logic                  locked
);
  localparam int bit_clks = ref_clk_freq / baudrate;
  localparam int half = bit_clks / 2;
  localparam int cw = $clog2(bit_clks);
  localparam logic [addr_width-1:0] last_addr = addr_width'((frame_length - 1) * 4);
  typedef enum logic [1:0] {idle, acquire, track} state_t;
  state_t state, next_state;
  logic phase_q, phase_qq, last;
  logic [cw-1:0] cnt;
  logic [4:0] bit_cnt;
  logic [31:0] shift;
  logic toggle, sample, rx_bit, word_done;
  assign ram_clk = clk;
  assign ram_rst = 1'b0;
  assign toggle = phase_q ^ phase_qq;
  assign sample = state == track && rx_enable && !toggle && cnt == '0;
  assign rx_bit = phase_q ^ last;
  assign word_done = sample && bit_cnt == 5'd31;
  always_comb next_state = !rx_enable ? idle : state == idle ? acquire : (state == acquire && toggle) ? track : state;
  always_ff @(posedge clk) state <= !rst_n ? idle : next_state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      phase_qq <= 1'b0;
      last <= 1'b0;
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      locked <= 1'b0;
      bit_tick <= 1'b0;
      bit_out <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 4'h0;
      ram_addr <= '0;
      ram_wr_data <= '0;
      frame_done <= 1'b0;
    end else begin
      phase_q <= phase_in;
      phase_qq <= phase_q;
      locked <= next_state == track;
      bit_tick <= sample;
      bit_out <= sample & rx_bit;
      ram_en <= word_done;
      ram_we <= {4{word_done}};
      frame_done <= word_done && ram_addr == last_addr;
      if (ram_en) ram_addr <= ram_addr == last_addr ? '0 : ram_addr + addr_width'(4);
      if (state == acquire && toggle) begin
        cnt <= cw'(half - 1);
        last <= phase_qq;
      end
      if (state == track) cnt <= toggle ? cw'(half - 1) : cnt == '0 ? cw'(bit_clks - 1) : cnt - 1'b1;
      if (sample) begin
        last <= phase_q;
        shift <= {shift[30:0], rx_bit};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (word_done) ram_wr_data <= data_width'({shift[30:0], rx_bit});
      if (state == idle && rx_enable) begin
        ram_addr <= '0;
        bit_cnt <= '0;
        shift <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bpsk_rx_ctrl.sv
// tb_bpsk_rx_ctrl: scoreboard bench for bpsk_rx_ctrl at 16 clk per bit
module tb_bpsk_rx_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_enable = 1'b0;
  logic phase_in = 1'b0;
  logic ram_clk, ram_en, ram_rst, bit_tick, bit_out, frame_done, locked;
  logic [3:0] ram_we;
  logic [31:0] ram_addr, ram_wr_data;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic fd;
  } wr_t;
  wr_t exp_wr[$];
  logic exp_bits[$];
  int total = 0;
  int bad = 0;
  int ticks = 0;
  int writes = 0;
  logic lvl = 1'b0;
  logic [31:0] exp_addr = 0;
  bpsk_rx_ctrl #(
    .data_width(32),
    .frame_length(38),
    .addr_width(32),
    .ref_clk_freq(160),
    .baudrate(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_enable(rx_enable),
    .phase_in(phase_in),
    .ram_clk(ram_clk),
    .ram_en(ram_en),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rst(ram_rst),
    .bit_tick(bit_tick),
    .bit_out(bit_out),
    .frame_done(frame_done),
    .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b, input int p);
    if (b) lvl = ~lvl;
    phase_in = lvl;
    exp_bits.push_back(b);
    cycles(p);
  endtask
  task automatic send_word(input logic [31:0] w, input int nb, input int p);
    for (int i = 31; i >= 32 - nb; i--) send_bit(w[i], p);
  endtask
  task automatic push_wr(input logic [31:0] d);
    wr_t e;
    e.addr = exp_addr;
    e.data = d;
    e.fd = exp_addr == 32'd148;
    exp_wr.push_back(e);
    exp_addr = exp_addr == 32'd148 ? 32'd0 : exp_addr + 32'd4;
  endtask
  task automatic restart();
    rx_enable = 1'b0;
    cycles(3);
    rx_enable = 1'b1;
    cycles(3);
    exp_addr = 0;
  endtask
  always @(negedge clk) begin
    if (bit_tick) begin
      ticks++;
      chk("bit_avail", 64'(exp_bits.size() > 0), 1);
      if (exp_bits.size() > 0) chk("bit_out", bit_out, exp_bits.pop_front());
    end
    if (ram_en) begin
      wr_t e;
      writes++;
      chk("wr_avail", 64'(exp_wr.size() > 0), 1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        chk("ram_we", ram_we, 4'hF);
        chk("ram_addr", ram_addr, e.addr);
        chk("ram_wr_data", ram_wr_data, e.data);
        chk("frame_done", frame_done, e.fd);
      end
    end
    if (frame_done) chk("fd_with_strobe", ram_en, 1);
  end
  initial begin
    int t0, w0;
    rst_n = 1'b0;
    rx_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      phase_in = ~phase_in;
      cycles(1);
    end
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wr_data", ram_wr_data, 0);
    chk("rst_ram_rst", ram_rst, 0);
    chk("rst_bit_tick", bit_tick, 0);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_locked", locked, 0);
    chk("ram_clk", ram_clk, 1);
    rx_enable = 1'b0;
    lvl = phase_in;
    rst_n = 1'b1;
    cycles(4);
    chk("idle_locked", locked, 0);
    restart();
    t0 = ticks;
    w0 = writes;
    push_wr(32'hA5A5A5A5);
    send_word(32'hA5A5A5A5, 32, 16);
    chk("single_ticks", ticks - t0, 32);
    chk("single_writes", writes - w0, 1);
    chk("single_addr_after", ram_addr, 4);
    chk("single_locked", locked, 1);
    restart();
    for (int i = 0; i < 39; i++) begin
      push_wr(32'h80000000 + i);
      send_word(32'h80000000 + i, 32, 16);
    end
    chk("wrap_addr_after", ram_addr, 4);
    restart();
    for (int i = 0; i < 38; i++) begin
      push_wr(32'hDEADBEEF);
      send_word(32'hDEADBEEF, 32, i < 19 ? 15 : 17);
    end
    chk("drift_addr_after", ram_addr, 0);
    restart();
    w0 = writes;
    send_word(32'hDEADBEEF, 20, 16);
    restart();
    push_wr(32'hC0FFEE01);
    send_word(32'hC0FFEE01, 32, 16);
    chk("drop_writes", writes - w0, 1);
    chk("drop_addr_after", ram_addr, 4);
    restart();
    push_wr(32'h80000000);
    push_wr(32'h00000000);
    send_bit(1'b1, 16);
    for (int i = 0; i < 63; i++) begin
      send_bit(1'b0, 16);
      chk("zero_run_locked", locked, 1);
    end
    chk("zero_addr_after", ram_addr, 8);
    rx_enable = 1'b0;
    cycles(5);
    chk("unlock_after_disable", locked, 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("bit_queue_empty", exp_bits.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
